// File: rtl/commit_trace_buffer_if.sv
// Commit-stream input and trace readout port of the commit trace buffer.
// The master side is the CPU/debug consumer; the slave side is the buffer.
interface commit_trace_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              commit_valid;
    logic [ADDR_W-1:0] commit_pc;
    logic [DATA_W-1:0] commit_inst;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    logic              out_ready;
    logic              out_valid;
    logic [ADDR_W-1:0] out_pc;
    logic [DATA_W-1:0] out_inst;
    logic              out_we;
    logic [4:0]        out_waddr;
    logic [DATA_W-1:0] out_wdata;

    modport master (
        output commit_valid, commit_pc, commit_inst, rf_we, rf_waddr, rf_wdata,
        output out_ready,
        input  out_valid, out_pc, out_inst, out_we, out_waddr, out_wdata
    );

    modport slave (
        input  commit_valid, commit_pc, commit_inst, rf_we, rf_waddr, rf_wdata,
        input  out_ready,
        output out_valid, out_pc, out_inst, out_we, out_waddr, out_wdata
    );
endinterface

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: records every retired instruction (pc, instruction word,
// register-file write) into a circular register array while capturing, stops on
// a zero instruction once enough history exists, then drains oldest-first.
module commit_trace_buffer #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 64,
    parameter int MIN_COUNT = 20,
    parameter int OVERWRITE = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     arm,
    commit_trace_buffer_if.slave     bus,
    output logic                     capturing,
    output logic                     halted,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level,
    output logic [31:0]              commit_cnt
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_W + 2*DATA_W + 6;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_HALTED  = 2'd2;

    logic [1:0]         state_r;
    logic [1:0]         state_nxt_s;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [LVL_W-1:0]   level_r;
    logic [31:0]        commit_cnt_r;
    logic               overflow_r;
    logic [ENTRY_W-1:0] mem_r [DEPTH];

    logic               in_capture_s;
    logic               halt_commit_s;
    logic               store_s;
    logic               full_s;
    logic               drop_s;
    logic               write_s;
    logic               pop_s;
    logic               rearm_s;
    logic               out_valid_s;
    logic [ENTRY_W-1:0] wr_entry_s;
    logic [ENTRY_W-1:0] head_s;

    assign in_capture_s  = (state_r == ST_CAPTURE);
    // commit_cnt_r is the count before this cycle's commit, as the halt rule needs
    assign halt_commit_s = bus.commit_valid && (bus.commit_inst == '0) &&
                           (commit_cnt_r >= 32'(MIN_COUNT));
    assign store_s       = in_capture_s && bus.commit_valid && !halt_commit_s;
    assign full_s        = (level_r == LVL_W'(DEPTH));
    assign drop_s        = store_s && full_s && (OVERWRITE == 0);
    assign write_s       = store_s && !drop_s;
    assign rearm_s       = arm && !in_capture_s;
    assign out_valid_s   = (state_r == ST_HALTED) && (level_r != '0);
    assign pop_s         = out_valid_s && bus.out_ready;
    assign wr_entry_s    = {bus.commit_pc, bus.commit_inst, bus.rf_we,
                            bus.rf_waddr, bus.rf_wdata};
    assign head_s        = mem_r[rd_ptr_r];

    assign capturing  = in_capture_s;
    assign halted     = (state_r == ST_HALTED);
    assign overflow   = overflow_r;
    assign level      = level_r;
    assign commit_cnt = commit_cnt_r;

    // Next-state decode: arm starts capture, halt commit or a dropped entry ends it
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (arm) begin
                    state_nxt_s = ST_CAPTURE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                if (halt_commit_s || drop_s) begin
                    state_nxt_s = ST_HALTED;
                end else begin
                    state_nxt_s = ST_CAPTURE;
                end
            end
            ST_HALTED: begin
                if (arm) begin
                    state_nxt_s = ST_CAPTURE;
                end else begin
                    state_nxt_s = ST_HALTED;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Pointers, fill level, commit counter and sticky overflow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            level_r      <= '0;
            commit_cnt_r <= 32'd0;
            overflow_r   <= 1'b0;
        end else if (rearm_s) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            level_r      <= '0;
            commit_cnt_r <= 32'd0;
            overflow_r   <= 1'b0;
        end else begin
            if (write_s) begin
                // pointers wrap naturally because DEPTH is a power of two
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                if (commit_cnt_r != 32'hFFFF_FFFF) begin
                    commit_cnt_r <= commit_cnt_r + 32'd1;
                end
                if (full_s) begin
                    // full in overwrite mode: newest entry replaces the oldest
                    rd_ptr_r   <= rd_ptr_r + PTR_W'(1);
                    overflow_r <= 1'b1;
                end else begin
                    level_r <= level_r + LVL_W'(1);
                end
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                level_r  <= level_r - LVL_W'(1);
            end
        end
    end

    // Trace storage; contents are don't-care after reset so no reset branch
    always_ff @(posedge clk) begin
        if (write_s) begin
            mem_r[wr_ptr_r] <= wr_entry_s;
        end
    end

    // Head-of-buffer presentation, forced to zero when nothing is offered
    always_comb begin
        bus.out_valid = out_valid_s;
        if (out_valid_s) begin
            bus.out_pc    = head_s[ENTRY_W-1 -: ADDR_W];
            bus.out_inst  = head_s[2*DATA_W+5 -: DATA_W];
            bus.out_we    = head_s[DATA_W+5];
            bus.out_waddr = head_s[DATA_W+4 -: 5];
            bus.out_wdata = head_s[DATA_W-1:0];
        end else begin
            bus.out_pc    = '0;
            bus.out_inst  = '0;
            bus.out_we    = 1'b0;
            bus.out_waddr = 5'd0;
            bus.out_wdata = '0;
        end
    end
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Scoreboard bench for commit_trace_buffer: three instances cover the default
// configuration, DEPTH=8 overwrite with MIN_COUNT=0, and DEPTH=8 stop-on-full.
module tb_commit_trace_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  arm;
    logic [2:0]  rdy;
    logic        cv;
    logic [31:0] cpc, cinst, cwd;
    logic        cwe;
    logic [4:0]  cwa;
    int          sel;

    logic [2:0]  cap, hlt, ovf;
    logic [6:0]  lvl0;
    logic [3:0]  lvl1, lvl2;
    logic [31:0] cnt0, cnt1, cnt2;

    logic        mv, mwe, mcap, mhlt, movf;
    logic [31:0] mpc, minst, mwd, mcnt;
    logic [4:0]  mwa;
    logic [6:0]  mlvl;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } ent_t;

    ent_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    commit_trace_buffer_if #(.ADDR_W(32), .DATA_W(32)) if0 ();
    commit_trace_buffer_if #(.ADDR_W(32), .DATA_W(32)) if1 ();
    commit_trace_buffer_if #(.ADDR_W(32), .DATA_W(32)) if2 ();

    assign if0.commit_valid = cv;   assign if1.commit_valid = cv;   assign if2.commit_valid = cv;
    assign if0.commit_pc    = cpc;  assign if1.commit_pc    = cpc;  assign if2.commit_pc    = cpc;
    assign if0.commit_inst  = cinst; assign if1.commit_inst = cinst; assign if2.commit_inst = cinst;
    assign if0.rf_we        = cwe;  assign if1.rf_we        = cwe;  assign if2.rf_we        = cwe;
    assign if0.rf_waddr     = cwa;  assign if1.rf_waddr     = cwa;  assign if2.rf_waddr     = cwa;
    assign if0.rf_wdata     = cwd;  assign if1.rf_wdata     = cwd;  assign if2.rf_wdata     = cwd;
    assign if0.out_ready    = rdy[0];
    assign if1.out_ready    = rdy[1];
    assign if2.out_ready    = rdy[2];

    commit_trace_buffer #(.ADDR_W(32), .DATA_W(32), .DEPTH(64), .MIN_COUNT(20), .OVERWRITE(1)) u0 (
        .clk(clk), .reset(reset), .arm(arm[0]), .bus(if0.slave), .capturing(cap[0]),
        .halted(hlt[0]), .overflow(ovf[0]), .level(lvl0), .commit_cnt(cnt0));
    commit_trace_buffer #(.ADDR_W(32), .DATA_W(32), .DEPTH(8), .MIN_COUNT(0), .OVERWRITE(1)) u1 (
        .clk(clk), .reset(reset), .arm(arm[1]), .bus(if1.slave), .capturing(cap[1]),
        .halted(hlt[1]), .overflow(ovf[1]), .level(lvl1), .commit_cnt(cnt1));
    commit_trace_buffer #(.ADDR_W(32), .DATA_W(32), .DEPTH(8), .MIN_COUNT(20), .OVERWRITE(0)) u2 (
        .clk(clk), .reset(reset), .arm(arm[2]), .bus(if2.slave), .capturing(cap[2]),
        .halted(hlt[2]), .overflow(ovf[2]), .level(lvl2), .commit_cnt(cnt2));

    // Route the selected instance's observable outputs to common names
    always_comb begin
        case (sel)
            1: begin
                mv = if1.out_valid; mpc = if1.out_pc; minst = if1.out_inst; mwe = if1.out_we;
                mwa = if1.out_waddr; mwd = if1.out_wdata; mlvl = {3'd0, lvl1}; mcnt = cnt1;
                mcap = cap[1]; mhlt = hlt[1]; movf = ovf[1];
            end
            2: begin
                mv = if2.out_valid; mpc = if2.out_pc; minst = if2.out_inst; mwe = if2.out_we;
                mwa = if2.out_waddr; mwd = if2.out_wdata; mlvl = {3'd0, lvl2}; mcnt = cnt2;
                mcap = cap[2]; mhlt = hlt[2]; movf = ovf[2];
            end
            default: begin
                mv = if0.out_valid; mpc = if0.out_pc; minst = if0.out_inst; mwe = if0.out_we;
                mwa = if0.out_waddr; mwd = if0.out_wdata; mlvl = lvl0; mcnt = cnt0;
                mcap = cap[0]; mhlt = hlt[0]; movf = ovf[0];
            end
        endcase
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one commit for a cycle; when store=1 the reference model of a
    // DEPTH-entry buffer (overwrite or drop when full) records the entry.
    task automatic commit(input logic [31:0] pc, input logic [31:0] inst, input int k,
                          input bit store, input int depth, input bit ovw);
        ent_t e;
        e.pc   = pc;
        e.inst = inst;
        e.we   = k[0];
        e.wa   = k[4:0];
        e.wd   = pc ^ 32'hA5A5_0000;
        cv = 1'b1; cpc = e.pc; cinst = e.inst; cwe = e.we; cwa = e.wa; cwd = e.wd;
        if (store) begin
            if (exp_q.size() < depth) begin
                exp_q.push_back(e);
            end else if (ovw) begin
                exp_q.delete(0);
                exp_q.push_back(e);
            end
        end
        tick();
        cv = 1'b0;
    endtask

    task automatic pulse_arm(input int s);
        arm[s] = 1'b1;
        tick();
        arm[s] = 1'b0;
    endtask

    // Pop up to max_pops entries from instance s, comparing each against the model
    task automatic drain(input int s, input bit toggle, input int max_pops, input int budget);
        bit   r = 1'b1;
        int   pops = 0;
        int   cyc = 0;
        ent_t e;
        sel = s;
        while (cyc < budget) begin
            rdy[s] = r;
            #1;
            if (!mv) break;
            if (r) begin
                if (exp_q.size() == 0) begin
                    check_val("drain_extra_entry", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("drain_pc_inst", {mpc, minst}, {e.pc, e.inst});
                    check_val("drain_rf_write", {26'd0, mwe, mwa, mwd}, {26'd0, e.we, e.wa, e.wd});
                end
                pops++;
            end
            tick();
            if (toggle) r = ~r;
            cyc++;
            if (pops >= max_pops) break;
        end
        rdy[s] = 1'b0;
        check_val("drain_in_budget", 64'(cyc < budget), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; arm = 3'd0; rdy = 3'd0; cv = 1'b0; sel = 0;
        cpc = 32'd0; cinst = 32'd0; cwe = 1'b0; cwa = 5'd0; cwd = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_out_valid", 64'(mv), 64'd0);
        check_val("reset_level", 64'(mlvl), 64'd0);
        check_val("reset_commit_cnt", 64'(mcnt), 64'd0);
        check_val("reset_flags", {61'd0, mcap, mhlt, movf}, 64'd0);
        #2 reset = 1'b1;
        tick();

        // Idle: commits are ignored until armed
        commit(32'h0000_0100, 32'h1111_1111, 0, 1'b0, 64, 1'b1);
        check_val("idle_ignores_commit", 64'(mlvl), 64'd0);

        // Basic capture, halt on zero after 25 commits, full drain in order
        pulse_arm(0);
        check_val("arm_capturing", 64'(mcap), 64'd1);
        for (int k = 0; k < 25; k++) commit(32'h0040_0000 + 32'(4*k), 32'h2001_0001, k, 1'b1, 64, 1'b1);
        commit(32'h0040_0064, 32'd0, 25, 1'b0, 64, 1'b1);
        check_val("t1_commit_cnt", 64'(mcnt), 64'd25);
        check_val("t1_halted", 64'(mhlt), 64'd1);
        check_val("t1_level", 64'(mlvl), 64'd25);
        check_val("t1_overflow", 64'(movf), 64'd0);
        drain(0, 1'b0, 1000, 100);
        check_val("t1_queue_empty", 64'(exp_q.size()), 64'd0);
        check_val("t1_valid_low", 64'(mv), 64'd0);

        // Early zero instruction is stored; halt only once count reaches MIN_COUNT
        pulse_arm(0);
        check_val("t2_rearm_level", 64'(mlvl), 64'd0);
        for (int k = 0; k < 24; k++)
            commit(32'h0000_1000 + 32'(4*k), (k == 3) ? 32'd0 : 32'h00A0_0093 + 32'(k), k, 1'b1, 64, 1'b1);
        check_val("t2_still_capturing", 64'(mcap), 64'd1);
        commit(32'h0000_1060, 32'd0, 24, 1'b0, 64, 1'b1);
        check_val("t2_halted", 64'(mhlt), 64'd1);
        check_val("t2_level", 64'(mlvl), 64'd24);
        check_val("t2_commit_cnt", 64'(mcnt), 64'd24);
        drain(0, 1'b1, 1000, 200);
        check_val("t2_queue_empty", 64'(exp_q.size()), 64'd0);
        check_val("t2_valid_low", 64'(mv), 64'd0);

        // Partial toggled drain, then re-arm mid-drain
        pulse_arm(0);
        for (int k = 0; k < 22; k++) commit(32'h0000_2000 + 32'(4*k), 32'h0000_0013, k, 1'b1, 64, 1'b1);
        commit(32'h0000_2058, 32'd0, 22, 1'b0, 64, 1'b1);
        drain(0, 1'b1, 3, 50);
        check_val("t5_level_after_pops", 64'(mlvl), 64'd19);
        pulse_arm(0);
        check_val("t5_rearm_level", 64'(mlvl), 64'd0);
        check_val("t5_rearm_capturing", 64'(mcap), 64'd1);
        check_val("t5_rearm_valid", 64'(mv), 64'd0);
        exp_q.delete();

        // DEPTH=8, overwrite, MIN_COUNT=0
        sel = 1;
        pulse_arm(1);
        for (int k = 0; k < 12; k++) commit(32'(4*k), 32'h0000_0013 + 32'(k << 7), k, 1'b1, 8, 1'b1);
        commit(32'd48, 32'd0, 12, 1'b0, 8, 1'b1);
        check_val("t3_level", 64'(mlvl), 64'd8);
        check_val("t3_overflow", 64'(movf), 64'd1);
        check_val("t3_halted", 64'(mhlt), 64'd1);
        check_val("t3_commit_cnt", 64'(mcnt), 64'd12);
        drain(1, 1'b0, 1000, 50);
        check_val("t3_queue_empty", 64'(exp_q.size()), 64'd0);
        check_val("t3_valid_low", 64'(mv), 64'd0);

        // DEPTH=8, stop on full
        sel = 2;
        pulse_arm(2);
        for (int k = 0; k < 8; k++) commit(32'h0000_3000 + 32'(4*k), 32'h0000_0033, k, 1'b1, 8, 1'b0);
        check_val("t4_not_yet_halted", 64'(mhlt), 64'd0);
        commit(32'h0000_3020, 32'h0000_0033, 8, 1'b1, 8, 1'b0);
        check_val("t4_halted", 64'(mhlt), 64'd1);
        check_val("t4_overflow", 64'(movf), 64'd1);
        check_val("t4_level", 64'(mlvl), 64'd8);
        check_val("t4_capturing", 64'(mcap), 64'd0);
        drain(2, 1'b0, 1000, 50);
        check_val("t4_queue_empty", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset in the middle of a capture
        sel = 1;
        pulse_arm(1);
        for (int k = 0; k < 5; k++) commit(32'h0000_4000 + 32'(4*k), 32'h0000_0013, k, 1'b0, 8, 1'b1);
        check_val("t6_level_before", 64'(mlvl), 64'd5);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("t6_reset_level", 64'(mlvl), 64'd0);
        check_val("t6_reset_state", {62'd0, mcap, mhlt}, 64'd0);
        check_val("t6_reset_cnt", 64'(mcnt), 64'd0);
        #2 reset = 1'b1;
        for (int k = 0; k < 3; k++) commit(32'h0000_5000 + 32'(4*k), 32'h0000_0013, k, 1'b0, 8, 1'b1);
        check_val("t6_ignored_level", 64'(mlvl), 64'd0);
        check_val("t6_ignored_cap", 64'(mcap), 64'd0);
        pulse_arm(1);
        check_val("t6_arm_capturing", 64'(mcap), 64'd1);
        commit(32'h0000_6000, 32'h0000_0013, 0, 1'b0, 8, 1'b1);
        check_val("t6_level_after_arm", 64'(mlvl), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
